// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the 5-stage pipeline hazard controller:
// forwarding selects, FSM states and the register-match helper.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] REG_ZERO  = 5'd0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // A later stage supplies src only if it writes a real (non-$zero) register.
    function automatic logic reg_match(input logic       we,
                                       input logic [4:0] dst,
                                       input logic [4:0] src);
        return we && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Single-operand EXE forwarding select; the younger EXE/MEM result wins
// over MEM/WB because it holds the more recent value of the register.
module fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_dst,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_dst,
    output logic [1:0] sel
);

    always_comb begin
        // NOTE: assign a default first so no path leaves sel unassigned (no latch).
        sel = FWD_REG;
        if (reg_match(mem_reg_write, mem_dst, src)) begin
            sel = FWD_EXMEM;
        end else if (reg_match(wb_reg_write, wb_dst, src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall / branch flush sequencer with forwarding, ID bypass and
// saturating event counters for the 5-stage MIPS pipeline.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_dst,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_dst,
    input  logic             mem_branch_taken,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_dst,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             id_byp_a,
    output logic             id_byp_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             busy
);

    localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL - 1);

    state_t           state;
    logic [1:0]       remain;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             lu;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;

    assign lu = ex_mem_read && (ex_dst != REG_ZERO) &&
                ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!reset) begin
            if (mem_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (state == STALL || lu) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    fwd_sel u_fwd_a (
        .src           (ex_rs),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .sel           (fwd_a_raw)
    );

    fwd_sel u_fwd_b (
        .src           (ex_rt),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .sel           (fwd_b_raw)
    );

    assign fwd_a     = reset ? FWD_REG : fwd_a_raw;
    assign fwd_b     = reset ? FWD_REG : fwd_b_raw;
    assign id_byp_a  = !reset && reg_match(wb_reg_write, wb_dst, id_rs);
    assign id_byp_b  = !reset && reg_match(wb_reg_write, wb_dst, id_rt);
    assign stall_cnt = reset ? '0 : stall_q;
    assign flush_cnt = reset ? '0 : flush_q;
    assign busy      = !reset && (state == STALL);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RUN;
            remain  <= 2'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (id_ex_bubble && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (mem_branch_taken && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end

            if (mem_branch_taken) begin
                state  <= RUN;
                remain <= 2'd0;
            end else begin
                case (state)
                    RUN: begin
                        if (lu && (LOAD_STALL > 1)) begin
                            state  <= STALL;
                            remain <= STALL_INIT;
                        end
                    end
                    STALL: begin
                        if (remain <= 2'd1) begin
                            state  <= RUN;
                            remain <= 2'd0;
                        end else begin
                            remain <= remain - 2'd1;
                        end
                    end
                    default: begin
                        state  <= RUN;
                        remain <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench: two controllers (1-cycle and 3-cycle load stall,
// 4-bit counters) share stimulus; expectations are queued then compared.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    logic       clock;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic       id_uses_rt, ex_mem_read, mem_reg_write, mem_branch_taken, wb_reg_write;

    logic             pc1, ifw1, bub1, iff1, ief1, emf1, bypa1, bypb1, busy1;
    logic [1:0]       fwda1, fwdb1;
    logic [CNT_W-1:0] scnt1, fcnt1;
    logic             pc3, ifw3, bub3, iff3, ief3, emf3, bypa3, bypb3, busy3;
    logic [1:0]       fwda3, fwdb3;
    logic [CNT_W-1:0] scnt3, fcnt3;

    pipe_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(CNT_W)) dut1 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_branch_taken(mem_branch_taken),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
        .pc_write(pc1), .if_id_write(ifw1), .id_ex_bubble(bub1), .if_id_flush(iff1),
        .id_ex_flush(ief1), .ex_mem_flush(emf1), .fwd_a(fwda1), .fwd_b(fwdb1),
        .id_byp_a(bypa1), .id_byp_b(bypb1), .stall_cnt(scnt1), .flush_cnt(fcnt1), .busy(busy1)
    );

    pipe_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(CNT_W)) dut3 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
        .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_branch_taken(mem_branch_taken),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
        .pc_write(pc3), .if_id_write(ifw3), .id_ex_bubble(bub3), .if_id_flush(iff3),
        .id_ex_flush(ief3), .ex_mem_flush(emf3), .fwd_a(fwda3), .fwd_b(fwdb3),
        .id_byp_a(bypa3), .id_byp_b(bypb3), .stall_cnt(scnt3), .flush_cnt(fcnt3), .busy(busy3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=queued_value", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_mem_read = 1'b0; ex_dst = 5'd0;
        mem_reg_write = 1'b0; mem_dst = 5'd0; mem_branch_taken = 1'b0;
        wb_reg_write = 1'b0; wb_dst = 5'd0;
    endtask

    // lw $2 in EXE, consumer reads $2 as rs in ID
    task automatic hazard();
        idle();
        ex_mem_read = 1'b1; ex_dst = 5'd2; id_rs = 5'd2;
    endtask

    initial begin
        idle();
        reset = 1'b1;

        // reset forces outputs even with hazard, branch, forward and bypass inputs active
        @(negedge clock);
        hazard();
        ex_rs = 5'd5; mem_reg_write = 1'b1; mem_dst = 5'd5;
        wb_reg_write = 1'b1; wb_dst = 5'd7; id_rt = 5'd7; mem_branch_taken = 1'b1;
        push("rst_pc_write", 1); push("rst_if_id_write", 1); push("rst_bubble", 0);
        push("rst_if_id_flush", 0); push("rst_fwd_a", 0); push("rst_byp_b", 0);
        #2;
        check(pc3); check(ifw3); check(bub3); check(iff3); check(fwda3); check(bypb3);

        @(negedge clock);
        idle();
        reset = 1'b0;
        push("init_stall_cnt", 0); push("init_flush_cnt", 0); push("init_busy", 0); push("init_pc_write", 1);
        #2;
        check(scnt3); check(fcnt3); check(busy3); check(pc3);

        // load-use: 1 bubble on dut1, 3 bubbles on dut3
        @(negedge clock);
        hazard();
        push("a1_pc1", 0); push("a1_ifw1", 0); push("a1_bub1", 1); push("a1_bub3", 1); push("a1_busy3", 0);
        #2;
        check(pc1); check(ifw1); check(bub1); check(bub3); check(busy3);

        @(negedge clock);
        idle();
        push("a2_pc1", 1); push("a2_bub1", 0); push("a2_scnt1", 1);
        push("a2_bub3", 1); push("a2_busy3", 1); push("a2_scnt3", 1);
        #2;
        check(pc1); check(bub1); check(scnt1); check(bub3); check(busy3); check(scnt3);

        @(negedge clock);
        push("a3_bub3", 1); push("a3_pc3", 0); push("a3_busy3", 1); push("a3_scnt3", 2);
        #2;
        check(bub3); check(pc3); check(busy3); check(scnt3);

        @(negedge clock);
        push("a4_bub3", 0); push("a4_pc3", 1); push("a4_busy3", 0); push("a4_scnt3", 3);
        #2;
        check(bub3); check(pc3); check(busy3); check(scnt3);

        // branch taken in the second STALL cycle of dut3
        @(negedge clock);
        hazard();
        push("b1_bub3", 1);
        #2;
        check(bub3);

        @(negedge clock);
        idle();
        push("b2_bub3", 1); push("b2_busy3", 1);
        #2;
        check(bub3); check(busy3);

        @(negedge clock);
        mem_branch_taken = 1'b1;
        push("b3_iff3", 1); push("b3_ief3", 1); push("b3_emf3", 1);
        push("b3_pc3", 1); push("b3_ifw3", 1); push("b3_bub3", 0); push("b3_busy3", 1);
        #2;
        check(iff3); check(ief3); check(emf3); check(pc3); check(ifw3); check(bub3); check(busy3);

        @(negedge clock);
        idle();
        push("b4_busy3", 0); push("b4_fcnt3", 1); push("b4_scnt3", 5); push("b4_fcnt1", 1); push("b4_scnt1", 2);
        #2;
        check(busy3); check(fcnt3); check(scnt3); check(fcnt1); check(scnt1);

        // load-use and branch together: only the flush acts
        @(negedge clock);
        hazard();
        mem_branch_taken = 1'b1;
        push("c1_bub1", 0); push("c1_pc1", 1); push("c1_emf1", 1);
        #2;
        check(bub1); check(pc1); check(emf1);

        @(negedge clock);
        idle();
        push("c2_scnt1", 2); push("c2_fcnt1", 2); push("c2_busy3", 0); push("c2_scnt3", 5);
        #2;
        check(scnt1); check(fcnt1); check(busy3); check(scnt3);

        // forwarding priority and register-zero exclusion
        @(negedge clock);
        ex_rs = 5'd5; mem_dst = 5'd5; wb_dst = 5'd5; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        push("d1_fwd_a_exmem", 1); push("d1_byp_a", 0);
        #2;
        check(fwda1); check(bypa1);

        @(negedge clock);
        mem_reg_write = 1'b0;
        push("d2_fwd_a_memwb", 2);
        #2;
        check(fwda1);

        @(negedge clock);
        ex_rs = 5'd0; mem_dst = 5'd0; wb_dst = 5'd0; mem_reg_write = 1'b1;
        push("d3_fwd_a_zero", 0); push("d3_fwd_b_zero", 0);
        #2;
        check(fwda1); check(fwdb1);

        @(negedge clock);
        ex_rs = 5'd4; ex_rt = 5'd6; mem_dst = 5'd6; wb_dst = 5'd6;
        push("d4_fwd_b_exmem", 1); push("d4_fwd_a_none", 0);
        #2;
        check(fwdb3); check(fwda3);

        @(negedge clock);
        mem_dst = 5'd9;
        push("d5_fwd_b_memwb", 2);
        #2;
        check(fwdb3);

        // ID bypass, and rt hazard only when the ID instruction reads rt
        @(negedge clock);
        idle();
        wb_reg_write = 1'b1; wb_dst = 5'd7; id_rt = 5'd7; id_rs = 5'd3;
        ex_mem_read = 1'b1; ex_dst = 5'd7;
        push("e1_byp_b", 1); push("e1_byp_a", 0); push("e1_pc1_no_rt", 1); push("e1_bub1", 0);
        #2;
        check(bypb1); check(bypa1); check(pc1); check(bub1);

        @(negedge clock);
        id_uses_rt = 1'b1;
        push("e2_pc1_rt_hazard", 0); push("e2_bub3", 1);
        #2;
        check(pc1); check(bub3);

        @(negedge clock);
        idle();
        @(negedge clock);

        // saturate stall counters; 22 events leaves dut3 mid-STALL
        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            hazard();
            push($sformatf("f_bub1_%0d", i), 1);
            push($sformatf("f_bub3_%0d", i), 1);
            #2;
            check(bub1); check(bub3);
        end

        @(negedge clock);
        idle();
        push("sat_scnt1", 15); push("sat_scnt3", 15); push("sat_busy3", 1);
        #2;
        check(scnt1); check(scnt3); check(busy3);

        @(negedge clock);
        reset = 1'b1;
        push("rst2_busy3", 0); push("rst2_pc3", 1); push("rst2_bub3", 0);
        #2;
        check(busy3); check(pc3); check(bub3);

        @(negedge clock);
        reset = 1'b0;
        push("post_scnt1", 0); push("post_scnt3", 0); push("post_fcnt3", 0);
        push("post_busy3", 0); push("post_bub3", 0); push("post_pc3", 1);
        #2;
        check(scnt1); check(scnt3); check(fcnt3); check(busy3); check(bub3); check(pc3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline (IF, ID, EXE, MEM, WB). It detects load-use hazards and stalls PC and IF/ID while injecting bubbles into ID/EXE. It flushes the three younger stages when a beq resolves taken in MEM. It generates EXE-stage forwarding selects and ID-stage register-file bypass selects, and keeps saturating stall and flush event counters.

## Interface
Parameters:
- LOAD_STALL, default 1: bubbles inserted per load-use hazard; legal range 1..3.
- CNT_W, default 16: width of the event counters.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- id_rs, id_rt  in  5 each  source register fields of the instruction in IF/ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw).
- ex_rs, ex_rt  in  5 each  source registers of the instruction in ID/EXE.
- ex_mem_read  in  1  ID/EXE instruction is lw.
- ex_dst  in  5  rt field of the ID/EXE instruction (lw destination).
- mem_reg_write  in  1  EXE/MEM WB regWrite bit.
- mem_dst  in  5  EXE/MEM destination register.
- mem_branch_taken  in  1  PCSrc (branch AND zero in MEM).
- wb_reg_write  in  1  MEM/WB regWrite bit.
- wb_dst  in  5  MEM/WB destination register.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- id_ex_bubble  out  1  zero the WB/MEM/EXE control fields entering ID/EXE.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  clear the corresponding pipeline register to nop on this edge.
- fwd_a, fwd_b  out  2 each  ALU operand source: 00 register, 01 EXE/MEM result, 10 MEM/WB writeData.
- id_byp_a, id_byp_b  out  1 each  ID read data replaced by the WB writeData.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.
- busy  out  1  FSM is in STALL.

## Operation
- FSM states: RUN and STALL. State register and counters reset to RUN and 0.
- Load-use hazard (lu): ex_mem_read && ex_dst != 0 && (ex_dst == id_rs || (id_uses_rt && ex_dst == id_rt)).
- In RUN, when lu && !mem_branch_taken:
  - pc_write=0, if_id_write=0, id_ex_bubble=1 in the same cycle.
  - If LOAD_STALL > 1, go to STALL with remaining counter = LOAD_STALL-1.
- In STALL, the same three stall outputs are held. The counter decrements each cycle; on reaching 0 the FSM returns to RUN. Hazard detection is ignored in STALL.
- mem_branch_taken has priority over everything:
  - All three flushes = 1, pc_write=1, if_id_write=1, id_ex_bubble=0.
  - The FSM goes to RUN and the stall counter clears.
- Forwarding for operand A:
  - fwd_a=01 if mem_reg_write && mem_dst != 0 && mem_dst == ex_rs.
  - Otherwise fwd_a=10 if wb_reg_write && wb_dst != 0 && wb_dst == ex_rs.
  - Otherwise 00.
  - EXE/MEM wins over MEM/WB. fwd_b is identical using ex_rt.
- ID bypass: id_byp_a = wb_reg_write && wb_dst != 0 && wb_dst == id_rs. id_byp_b is the same using id_rt.
- Counters:
  - stall_cnt increments every cycle id_ex_bubble=1.
  - flush_cnt increments every cycle mem_branch_taken=1.
  - Both saturate at all-ones and never wrap.

## Timing
- While reset is high, outputs are forced to: pc_write=1, if_id_write=1, all other outputs 0. Counters clear and state is RUN on the edge.
- Reset asserted mid-STALL aborts the stall; normal operation resumes on the first cycle after reset deasserts.
- Stall, flush, forward and bypass outputs are combinational (Mealy) from inputs and state, valid in the same cycle. Zero-cycle latency is required.
- Counters and busy are registered; they reflect an event one cycle after it occurs.
- If lu and mem_branch_taken occur in the same cycle, only the flush acts, and stall_cnt does not increment.

## Structure
- Package pipe_ctrl_pkg holds:
  - FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - The state encoding (RUN, STALL).
  - REG_ZERO=5'd0.
- Sub-module fwd_sel: combinational single-operand forwarding select, instantiated twice (A and B).
- Top level contains the FSM, stall counter, event counters and ID bypass logic.

## Test plan
- lw $2 in EXE, add using $2 as rs in ID, LOAD_STALL=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt=1 the next cycle.
- Same hazard with LOAD_STALL=3 -> three consecutive bubble cycles, busy=1 for the two cycles after detection, then RUN.
- mem_branch_taken=1 in the second STALL cycle -> all flushes=1 and pc_write=1 that cycle; flush_cnt=1; busy=0 the next cycle.
- mem_dst=wb_dst=ex_rs=5, both write enables high -> fwd_a=01. Repeat with mem_reg_write=0 -> fwd_a=10. Repeat with register 0 in every field -> fwd_a=00.
- wb_reg_write=1, wb_dst=7, id_rt=7, id_rs=3 -> id_byp_b=1, id_byp_a=0.
- Force 2^CNT_W+5 stall events (CNT_W=4 build) -> stall_cnt holds at 15; reset pulse -> 0.
